// File: rtl/mem_access.sv
// mem_access: RISC-V memory-access stage with a req/ack data bus and
// the MEM/WB pipeline register feeding write-back.
module mem_access #(
    parameter int XLEN = 32,
    parameter int RD_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic            ex_MemRead,
    input  logic            ex_MemWrite,
    input  logic            ex_MemtoReg,
    input  logic            ex_RegWrite,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] ex_ALU_result,
    input  logic [XLEN-1:0] ex_store_data,
    input  logic [RD_W-1:0] ex_rd,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_wstrb,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic            wb_MemtoReg,
    output logic            wb_RegWrite,
    output logic [XLEN-1:0] wb_mem_data,
    output logic [XLEN-1:0] wb_ALU_result,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_fault
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [2:0]        f3_q, f3_d;
    logic [RD_W-1:0]   rd_q, rd_d;
    logic              m2r_q, m2r_d;
    logic              rw_q, rw_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic              wb_m2r_q, wb_m2r_d;
    logic              wb_rw_q, wb_rw_d;
    logic [XLEN-1:0]   wb_mdata_q, wb_mdata_d;
    logic [XLEN-1:0]   wb_alu_q, wb_alu_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic              wb_fault_q, wb_fault_d;

    logic              is_mem, f3_ok, align_ok;
    logic [XLEN-1:0]   byte_sh, half_sh, load_val;
    logic [1:0]        off;

    assign off    = ex_ALU_result[1:0];
    assign is_mem = ex_MemRead | ex_MemWrite;

    always_comb begin
        f3_ok = 1'b0;
        if (ex_MemRead && !ex_MemWrite)
            f3_ok = ex_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        else if (ex_MemWrite && !ex_MemRead)
            f3_ok = ex_funct3 inside {3'b000, 3'b001, 3'b010};
        case (ex_funct3[1:0])
            2'b01:   align_ok = ~off[0];
            2'b10:   align_ok = (off == 2'b00);
            default: align_ok = 1'b1;
        endcase
    end

    // Lane selection for the returning load word, from the captured offset
    assign byte_sh = dmem_rdata >> {addr_q[1:0], 3'b000};
    assign half_sh = dmem_rdata >> {addr_q[1], 4'b0000};

    always_comb begin
        case (f3_q)
            3'b000:  load_val = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
            3'b001:  load_val = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, half_sh[15:0]};
            default: load_val = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        m2r_d      = m2r_q;
        rw_d       = rw_q;
        req_d      = req_q;
        we_d       = we_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        wb_valid_d = 1'b0;
        wb_m2r_d   = wb_m2r_q;
        wb_rw_d    = wb_rw_q;
        wb_mdata_d = wb_mdata_q;
        wb_alu_d   = wb_alu_q;
        wb_rd_d    = wb_rd_q;
        wb_fault_d = wb_fault_q;
        case (state_q)
            IDLE: begin
                if (ex_valid && !is_mem) begin
                    wb_valid_d = 1'b1;
                    wb_m2r_d   = ex_MemtoReg;
                    wb_rw_d    = ex_RegWrite;
                    wb_mdata_d = '0;
                    wb_alu_d   = ex_ALU_result;
                    wb_rd_d    = ex_rd;
                    wb_fault_d = 1'b0;
                end else if (ex_valid && f3_ok && align_ok) begin
                    state_d = BUSY;
                    addr_d  = ex_ALU_result;
                    f3_d    = ex_funct3;
                    rd_d    = ex_rd;
                    m2r_d   = ex_MemtoReg;
                    rw_d    = ex_RegWrite;
                    req_d   = 1'b1;
                    we_d    = ex_MemWrite;
                    wstrb_d = '0;
                    wdata_d = '0;
                    if (ex_MemWrite) begin
                        case (ex_funct3[1:0])
                            2'b00: begin
                                wstrb_d = 4'b0001 << off;
                                wdata_d = {4{ex_store_data[7:0]}};
                            end
                            2'b01: begin
                                wstrb_d = 4'b0011 << off;
                                wdata_d = {2{ex_store_data[15:0]}};
                            end
                            default: begin
                                wstrb_d = 4'b1111;
                                wdata_d = ex_store_data;
                            end
                        endcase
                    end
                end else if (ex_valid) begin
                    wb_valid_d = 1'b1;
                    wb_m2r_d   = ex_MemtoReg;
                    wb_rw_d    = 1'b0;
                    wb_mdata_d = '0;
                    wb_alu_d   = ex_ALU_result;
                    wb_rd_d    = ex_rd;
                    wb_fault_d = 1'b1;
                end
            end
            BUSY: begin
                if (dmem_ack) begin
                    state_d    = IDLE;
                    req_d      = 1'b0;
                    wb_valid_d = 1'b1;
                    wb_m2r_d   = m2r_q;
                    wb_rw_d    = rw_q & ~we_q;
                    wb_mdata_d = we_q ? '0 : load_val;
                    wb_alu_d   = addr_q;
                    wb_rd_d    = rd_q;
                    wb_fault_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            m2r_q      <= 1'b0;
            rw_q       <= 1'b0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            wstrb_q    <= '0;
            wdata_q    <= '0;
            wb_valid_q <= 1'b0;
            wb_m2r_q   <= 1'b0;
            wb_rw_q    <= 1'b0;
            wb_mdata_q <= '0;
            wb_alu_q   <= '0;
            wb_rd_q    <= '0;
            wb_fault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            m2r_q      <= m2r_d;
            rw_q       <= rw_d;
            req_q      <= req_d;
            we_q       <= we_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            wb_valid_q <= wb_valid_d;
            wb_m2r_q   <= wb_m2r_d;
            wb_rw_q    <= wb_rw_d;
            wb_mdata_q <= wb_mdata_d;
            wb_alu_q   <= wb_alu_d;
            wb_rd_q    <= wb_rd_d;
            wb_fault_q <= wb_fault_d;
        end
    end

    assign ex_ready      = (state_q == IDLE);
    assign dmem_req      = req_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = {addr_q[XLEN-1:2], 2'b00};
    assign dmem_wstrb    = wstrb_q;
    assign dmem_wdata    = wdata_q;
    assign wb_valid      = wb_valid_q;
    assign wb_MemtoReg   = wb_m2r_q;
    assign wb_RegWrite   = wb_rw_q;
    assign wb_mem_data   = wb_mdata_q;
    assign wb_ALU_result = wb_alu_q;
    assign wb_rd         = wb_rd_q;
    assign wb_fault      = wb_fault_q;

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: directed checks of the memory-access stage against
// hand-computed bus and write-back values.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        ex_valid = 1'b0;
    logic        ex_ready;
    logic        ex_MemRead = 1'b0;
    logic        ex_MemWrite = 1'b0;
    logic        ex_MemtoReg = 1'b0;
    logic        ex_RegWrite = 1'b0;
    logic [2:0]  ex_funct3 = '0;
    logic [31:0] ex_ALU_result = '0;
    logic [31:0] ex_store_data = '0;
    logic [4:0]  ex_rd = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic        wb_MemtoReg;
    logic        wb_RegWrite;
    logic [31:0] wb_mem_data;
    logic [31:0] wb_ALU_result;
    logic [4:0]  wb_rd;
    logic        wb_fault;

    int checks = 0;
    int errors = 0;

    mem_access #(.XLEN(32), .RD_W(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_MemRead(ex_MemRead), .ex_MemWrite(ex_MemWrite),
        .ex_MemtoReg(ex_MemtoReg), .ex_RegWrite(ex_RegWrite),
        .ex_funct3(ex_funct3), .ex_ALU_result(ex_ALU_result),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_MemtoReg(wb_MemtoReg),
        .wb_RegWrite(wb_RegWrite), .wb_mem_data(wb_mem_data),
        .wb_ALU_result(wb_ALU_result), .wb_rd(wb_rd), .wb_fault(wb_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rd, input logic wr,
                         input logic m2r, input logic rw,
                         input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] sd, input logic [4:0] rdi);
        ex_valid      = v;
        ex_MemRead    = rd;
        ex_MemWrite   = wr;
        ex_MemtoReg   = m2r;
        ex_RegWrite   = rw;
        ex_funct3     = f3;
        ex_ALU_result = alu;
        ex_store_data = sd;
        ex_rd         = rdi;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 3'b000, 32'h0, 32'h0, 5'd0);
    endtask

    // Load at addr, acked in the third request cycle with rdata
    task automatic load3(input string tag, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] rdata,
                         input logic [31:0] exp);
        drive(1, 1, 0, 1, 1, f3, addr, 32'h0, 5'd7);
        tick();
        idle();
        chk({tag, "_req"}, {31'd0, dmem_req}, 32'd1);
        chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
        chk({tag, "_we"}, {31'd0, dmem_we}, 32'd0);
        chk({tag, "_rdy1"}, {31'd0, ex_ready}, 32'd0);
        tick();
        chk({tag, "_rdy2"}, {31'd0, ex_ready}, 32'd0);
        tick();
        chk({tag, "_rdy3"}, {31'd0, ex_ready}, 32'd0);
        chk({tag, "_wbv_busy"}, {31'd0, wb_valid}, 32'd0);
        dmem_ack   = 1'b1;
        dmem_rdata = rdata;
        tick();
        dmem_ack   = 1'b0;
        dmem_rdata = 32'h0;
        chk({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
        chk({tag, "_data"}, wb_mem_data, exp);
        chk({tag, "_rdy"}, {31'd0, ex_ready}, 32'd1);
        chk({tag, "_reqoff"}, {31'd0, dmem_req}, 32'd0);
        chk({tag, "_rd"}, {27'd0, wb_rd}, 32'd7);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        chk("rst_req", {31'd0, dmem_req}, 32'd0);
        chk("rst_ready", {31'd0, ex_ready}, 32'd1);
        chk("rst_wbv", {31'd0, wb_valid}, 32'd0);
        chk("rst_addr", dmem_addr, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // ADD pass-through
        drive(1, 0, 0, 0, 1, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
        tick();
        idle();
        chk("add_wbv", {31'd0, wb_valid}, 32'd1);
        chk("add_alu", wb_ALU_result, 32'h0000_1234);
        chk("add_rd", {27'd0, wb_rd}, 32'd5);
        chk("add_rw", {31'd0, wb_RegWrite}, 32'd1);
        chk("add_md", wb_mem_data, 32'd0);
        chk("add_req", {31'd0, dmem_req}, 32'd0);
        tick();
        chk("add_pulse", {31'd0, wb_valid}, 32'd0);

        // Ack while idle must be ignored
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("ack_idle_wbv", {31'd0, wb_valid}, 32'd0);
        chk("ack_idle_req", {31'd0, dmem_req}, 32'd0);

        load3("lb", 3'b000, 32'h0000_0103, 32'h80FF_0000, 32'hFFFF_FF80);
        load3("lbu", 3'b100, 32'h0000_0103, 32'h80FF_0000, 32'h0000_0080);
        load3("lh", 3'b001, 32'h0000_0102, 32'h80FF_1234, 32'hFFFF_80FF);
        load3("lhu", 3'b101, 32'h0000_0100, 32'h1234_8001, 32'h0000_8001);

        // SH at 0x22
        drive(1, 0, 1, 0, 1, 3'b001, 32'h0000_0022, 32'hABCD_5678, 5'd9);
        tick();
        idle();
        chk("sh_req", {31'd0, dmem_req}, 32'd1);
        chk("sh_we", {31'd0, dmem_we}, 32'd1);
        chk("sh_addr", dmem_addr, 32'h0000_0020);
        chk("sh_wstrb", {28'd0, dmem_wstrb}, 32'hC);
        chk("sh_wdata", dmem_wdata, 32'h5678_5678);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("sh_wbv", {31'd0, wb_valid}, 32'd1);
        chk("sh_rw", {31'd0, wb_RegWrite}, 32'd0);
        chk("sh_fault", {31'd0, wb_fault}, 32'd0);

        // SB at 0x41
        drive(1, 0, 1, 0, 0, 3'b000, 32'h0000_0041, 32'h0000_00A5, 5'd0);
        tick();
        idle();
        chk("sb_wstrb", {28'd0, dmem_wstrb}, 32'h2);
        chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;

        // Misaligned LW
        drive(1, 1, 0, 1, 1, 3'b010, 32'h0000_0102, 32'h0, 5'd3);
        tick();
        idle();
        chk("mis_req", {31'd0, dmem_req}, 32'd0);
        chk("mis_wbv", {31'd0, wb_valid}, 32'd1);
        chk("mis_fault", {31'd0, wb_fault}, 32'd1);
        chk("mis_rw", {31'd0, wb_RegWrite}, 32'd0);
        chk("mis_rdy", {31'd0, ex_ready}, 32'd1);

        // Illegal funct3 load
        drive(1, 1, 0, 1, 1, 3'b011, 32'h0000_0100, 32'h0, 5'd3);
        tick();
        idle();
        chk("ill_req", {31'd0, dmem_req}, 32'd0);
        chk("ill_fault", {31'd0, wb_fault}, 32'd1);
        chk("ill_rw", {31'd0, wb_RegWrite}, 32'd0);

        // MemRead and MemWrite both set
        drive(1, 1, 1, 0, 1, 3'b010, 32'h0000_0100, 32'h0, 5'd3);
        tick();
        idle();
        chk("both_req", {31'd0, dmem_req}, 32'd0);
        chk("both_fault", {31'd0, wb_fault}, 32'd1);

        // SW followed by ADD held on ex_valid
        drive(1, 0, 1, 0, 0, 3'b010, 32'h0000_0040, 32'h1122_3344, 5'd0);
        tick();
        drive(1, 0, 0, 0, 1, 3'b000, 32'h0000_0777, 32'h0, 5'd11);
        chk("b2b_wstrb", {28'd0, dmem_wstrb}, 32'hF);
        chk("b2b_wdata", dmem_wdata, 32'h1122_3344);
        chk("b2b_rdy0", {31'd0, ex_ready}, 32'd0);
        tick();
        chk("b2b_hold_wbv", {31'd0, wb_valid}, 32'd0);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("b2b_st_wbv", {31'd0, wb_valid}, 32'd1);
        chk("b2b_st_alu", wb_ALU_result, 32'h0000_0040);
        chk("b2b_rdy1", {31'd0, ex_ready}, 32'd1);
        tick();
        idle();
        chk("b2b_add_wbv", {31'd0, wb_valid}, 32'd1);
        chk("b2b_add_alu", wb_ALU_result, 32'h0000_0777);
        chk("b2b_add_rd", {27'd0, wb_rd}, 32'd11);
        tick();
        chk("b2b_nodup", {31'd0, wb_valid}, 32'd0);

        // Reset in the middle of a BUSY transaction
        drive(1, 1, 0, 1, 1, 3'b010, 32'h0000_0200, 32'h0, 5'd12);
        tick();
        idle();
        chk("rb_req", {31'd0, dmem_req}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rb_req0", {31'd0, dmem_req}, 32'd0);
        chk("rb_addr0", dmem_addr, 32'd0);
        chk("rb_alu0", wb_ALU_result, 32'd0);
        chk("rb_rd0", {27'd0, wb_rd}, 32'd0);
        chk("rb_rdy", {31'd0, ex_ready}, 32'd1);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rb_idle_req", {31'd0, dmem_req}, 32'd0);
        drive(1, 1, 0, 1, 1, 3'b010, 32'h0000_0200, 32'h0, 5'd12);
        tick();
        idle();
        chk("rb_lw_req", {31'd0, dmem_req}, 32'd1);
        dmem_ack   = 1'b1;
        dmem_rdata = 32'hDEAD_BEEF;
        tick();
        dmem_ack   = 1'b0;
        chk("rb_lw_wbv", {31'd0, wb_valid}, 32'd1);
        chk("rb_lw_data", wb_mem_data, 32'hDEAD_BEEF);
        chk("rb_lw_rd", {27'd0, wb_rd}, 32'd12);
        chk("rb_lw_m2r", {31'd0, wb_MemtoReg}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the five-stage RISC-V pipeline: takes load/store and pass-through results from EX/MEM, runs a req/ack transaction on the data-memory bus, aligns and sign-extends load data, and holds the MEM/WB pipeline register that feeds write-back (MemtoReg, mem_data, ALU_result, rd). Multi-cycle memory latency stalls EX via `ex_ready`.

## Interface
- `XLEN`, 32: data/address width; only 32 is supported (4 byte lanes).
- `RD_W`, 5: destination-register index width.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  EX/MEM holds a valid instruction.
- `ex_ready`  out  1  stage accepts the instruction this cycle.
- `ex_MemRead`, `ex_MemWrite`, `ex_MemtoReg`, `ex_RegWrite`  in  1 each  control bits.
- `ex_funct3`  in  3  access size/sign.
- `ex_ALU_result`  in  XLEN  effective address or ALU value.
- `ex_store_data`  in  XLEN  rs2 value for stores.
- `ex_rd`  in  RD_W  destination register.
- `dmem_req`  out  1  bus request; held until `dmem_ack`.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  XLEN  word-aligned address.
- `dmem_wstrb`  out  4  byte-lane enables (store only).
- `dmem_wdata`  out  XLEN  lane-replicated store data.
- `dmem_ack`  in  1  transaction complete; `dmem_rdata` valid this cycle for loads.
- `dmem_rdata`  in  XLEN  load word.
- `wb_valid`, `wb_MemtoReg`, `wb_RegWrite`  out  1 each  MEM/WB register.
- `wb_mem_data`, `wb_ALU_result`  out  XLEN  MEM/WB register.
- `wb_rd`  out  RD_W  MEM/WB register.
- `wb_fault`  out  1  misaligned or illegal-funct3 access retired.

## Operation
- FSM states IDLE, BUSY. `ex_ready` = (state == IDLE).
- IDLE, `ex_valid`=0: MEM/WB loaded with `wb_valid`=0, other fields hold.
- IDLE, `ex_valid`=1, no MemRead/MemWrite: MEM/WB loaded directly (wb_mem_data=0, wb_fault=0); stay IDLE.
- IDLE, memory op, aligned and legal: capture address, funct3, store data, rd, control into holding regs; next state BUSY; MEM/WB loaded with `wb_valid`=0.
- IDLE, memory op, misaligned or illegal: no bus transaction; MEM/WB loaded with wb_valid=1, wb_fault=1, wb_RegWrite=0, wb_mem_data=0.
- Legal funct3: loads 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores 000 SB, 001 SH, 010 SW. Others illegal. Halfword needs addr[0]=0, word needs addr[1:0]=0.
- MemRead and MemWrite both set: treated as illegal.
- BUSY: `dmem_req`=1, `dmem_we`/`dmem_addr`/`dmem_wstrb`/`dmem_wdata` driven from holding regs, stable until ack. `dmem_addr` = {addr[31:2],2'b00}.
- Store lanes: SB wstrb=4'b0001<<addr[1:0], wdata={4{data[7:0]}}; SH wstrb=4'b0011<<addr[1:0], wdata={2{data[15:0]}}; SW wstrb=4'b1111. Loads: wstrb=0, wdata=0.
- BUSY, `dmem_ack`=0: MEM/WB loaded with wb_valid=0.
- BUSY, `dmem_ack`=1: MEM/WB loaded with captured fields, wb_valid=1, wb_fault=0; store forces wb_RegWrite=0; load wb_mem_data = selected byte/half at addr offset, sign-extended (LB/LH) or zero-extended (LBU/LHU), or full word (LW); next state IDLE.
- `dmem_ack` while IDLE: ignored.

## Timing
- Reset (async assert, any state incl. BUSY): state IDLE, `dmem_req`=0, all dmem_* outputs 0, every wb_* output 0. Outstanding transaction abandoned; bus slave must tolerate req drop.
- Non-memory or faulting instruction: accepted cycle T, visible on wb_* in T+1.
- Memory op accepted at T: `dmem_req` high from T+1; ack in cycle T+k (k≥1) → wb_* valid in T+k+1; `ex_ready` low T+1..T+k, high again T+k+1.
- Minimum memory latency 2 cycles (ack in first req cycle); throughput one memory op per 2 cycles, one non-memory op per cycle.
- wb_valid is a one-cycle pulse per retired instruction; no back-pressure from WB.

## Test plan
- ADD pass-through: ex_ALU_result=0x0000_1234, rd=5, RegWrite=1 → next cycle wb_valid=1, wb_ALU_result=0x1234, wb_rd=5, dmem_req never asserted.
- LB at 0x103, ack after 3 req cycles with rdata=0x80FF_0000 → dmem_addr=0x100, ex_ready low 3 cycles, wb_mem_data=0xFFFF_FF80; LBU same → 0x0000_0080.
- SH at 0x22 data 0xABCD_5678 → wstrb=4'b1100, wdata=0x5678_5678, we=1; retire with wb_RegWrite=0.
- LW at 0x102 → no dmem_req, next cycle wb_valid=1, wb_fault=1, wb_RegWrite=0; funct3=011 load → same.
- Back-to-back: SW then ADD held on ex_valid → ADD accepted the cycle after store ack, retired one cycle later; no instruction lost or duplicated.
- rst_n pulsed low mid-BUSY → dmem_req and all wb_* go 0 immediately; after release, ex_ready=1 and a fresh LW completes normally.
